// File: rtl/eth_pll_phase_ctrl_if.sv
// Command channel between the CSR block (master) and the PLL phase controller (slave).
// Handshake: a command transfers on a refclk edge where cmd_valid & cmd_ready are both 1;
// the master holds cmd_ch/cmd_dir/cmd_steps stable while cmd_valid is 1 and cmd_ready is 0.
interface eth_pll_phase_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_ch;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_ch, cmd_dir, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_dir, cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/eth_pll_phase_ctrl.sv
// Ethernet PLL runtime controller: PLL reset/lock qualification plus per-channel dynamic phase stepping.
// Optional macro ETH_PLL_AUTO_RELOCK_EN: lock loss re-resets the PLL and clears every phase accumulator.
module eth_pll_phase_ctrl #(
  parameter int NUM_CH    = 6,
  parameter int STEP_W    = 8,
  parameter int PHASE_W   = 10,
  parameter int RST_CYC   = 8,
  parameter int LOCK_FILT = 16,
  parameter int DONE_TMO  = 1024
) (
  input  logic                       refclk,
  input  logic                       rst,
  eth_pll_phase_ctrl_if.slave        cmd,
  input  logic                       pll_locked_i,
  output logic                       pll_rst_o,
  output logic                       phase_en_o,
  output logic                       updn_o,
  output logic [4:0]                 cntsel_o,
  input  logic                       phase_done_i,
  output logic                       locked_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_badch_o,
  output logic                       err_tmo_o,
  output logic [NUM_CH*PHASE_W-1:0]  ch_phase_o,
  output logic [2:0]                 state_o
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    IDLE      = 3'd2,
    STEP_EN   = 3'd3,
    STEP_WAIT = 3'd4,
    STEP_GAP  = 3'd5
  } state_e;

  localparam int RC_W = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;
  localparam int LF_W = $clog2(LOCK_FILT + 1);
  localparam int TM_W = $clog2(DONE_TMO + 1);

  localparam logic [RC_W-1:0] RST_LAST  = RC_W'(RST_CYC - 1);
  localparam logic [LF_W-1:0] FILT_LAST = LF_W'(LOCK_FILT - 1);
  localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(DONE_TMO - 1);
  localparam logic [4:0]      NUM_CH5   = 5'(NUM_CH);

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [LF_W-1:0]   filt_q, filt_d;
  logic [TM_W-1:0]   tmo_q, tmo_d;
  logic              en_cnt_q, en_cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [4:0]        ch_q, ch_d;
  logic              dir_q, dir_d;

  logic lock_s1_q, lock_s2_q;
  logic pd_s1_q, pd_s2_q, pd_s3_q, pd_edge_q;

  logic pll_rst_q, phase_en_q, cmd_ready_q, locked_q, busy_q;
  logic done_q, done_d, badch_q, badch_d, tmo_err_q, tmo_err_d;
  logic acc_clr, acc_step;

  // Both PLL status pins are asynchronous; phase_done gets an extra stage for edge detection.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      pd_s1_q   <= 1'b0;
      pd_s2_q   <= 1'b0;
      pd_s3_q   <= 1'b0;
      pd_edge_q <= 1'b0;
    end else begin
      lock_s1_q <= pll_locked_i;
      lock_s2_q <= lock_s1_q;
      pd_s1_q   <= phase_done_i;
      pd_s2_q   <= pd_s1_q;
      pd_s3_q   <= pd_s2_q;
      pd_edge_q <= pd_s2_q & ~pd_s3_q;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      rst_cnt_q <= '0;
      filt_q    <= '0;
      tmo_q     <= '0;
      en_cnt_q  <= 1'b0;
      rem_q     <= '0;
      ch_q      <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      filt_q    <= filt_d;
      tmo_q     <= tmo_d;
      en_cnt_q  <= en_cnt_d;
      rem_q     <= rem_d;
      ch_q      <= ch_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    filt_d    = filt_q;
    tmo_d     = tmo_q;
    en_cnt_d  = en_cnt_q;
    rem_d     = rem_q;
    ch_d      = ch_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    badch_d   = 1'b0;
    tmo_err_d = 1'b0;
    acc_clr   = 1'b0;
    acc_step  = 1'b0;

    case (state_q)
      RESET_PLL: begin
        acc_clr = 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (!lock_s2_q) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = IDLE;
        end else begin
          filt_d = filt_q + LF_W'(1);
        end
      end

      default: begin
        // Lock loss outranks everything else, including a coincident phase_done edge.
        if (!lock_s2_q) begin
`ifdef ETH_PLL_AUTO_RELOCK_EN
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
`else
          state_d   = WAIT_LOCK;
          filt_d    = '0;
`endif
        end else begin
          case (state_q)
            IDLE: begin
              if (cmd.cmd_valid) begin
                if (cmd.cmd_ch >= NUM_CH5) begin
                  badch_d = 1'b1;
                end else if (cmd.cmd_steps == '0) begin
                  done_d = 1'b1;
                end else begin
                  ch_d     = cmd.cmd_ch;
                  dir_d    = cmd.cmd_dir;
                  rem_d    = cmd.cmd_steps;
                  en_cnt_d = 1'b0;
                  state_d  = STEP_EN;
                end
              end
            end

            STEP_EN: begin
              if (en_cnt_q) begin
                state_d = STEP_WAIT;
                tmo_d   = '0;
              end else begin
                en_cnt_d = 1'b1;
              end
            end

            STEP_WAIT: begin
              if (pd_edge_q) begin
                acc_step = 1'b1;
                rem_d    = rem_q - STEP_W'(1);
                if (rem_q == STEP_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = STEP_GAP;
                end
              end else if (tmo_q == TMO_LAST) begin
                tmo_err_d = 1'b1;
                state_d   = IDLE;
              end else begin
                tmo_d = tmo_q + TM_W'(1);
              end
            end

            STEP_GAP: begin
              en_cnt_d = 1'b0;
              state_d  = STEP_EN;
            end

            default: state_d = RESET_PLL;
          endcase
        end
      end
    endcase
  end

  // Every status output is a flop loaded from the next state, so it lines up with state_q.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      phase_en_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      badch_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == RESET_PLL);
      phase_en_q  <= (state_d == STEP_EN);
      cmd_ready_q <= (state_d == IDLE);
      locked_q    <= (state_d == IDLE) || (state_d == STEP_EN) ||
                     (state_d == STEP_WAIT) || (state_d == STEP_GAP);
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      badch_q     <= badch_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_acc
    logic [PHASE_W-1:0] acc_q;

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (acc_clr) begin
        acc_q <= '0;
      end else if (acc_step && (ch_q == 5'(n))) begin
        acc_q <= dir_q ? acc_q + PHASE_W'(1) : acc_q - PHASE_W'(1);
      end
    end

    assign ch_phase_o[n*PHASE_W +: PHASE_W] = acc_q;
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign pll_rst_o     = pll_rst_q;
  assign phase_en_o    = phase_en_q;
  assign updn_o        = dir_q;
  assign cntsel_o      = ch_q;
  assign locked_o      = locked_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_badch_o   = badch_q;
  assign err_tmo_o     = tmo_err_q;
  assign state_o       = state_q;

endmodule

// File: doc/eth_pll_phase_ctrl.md
# eth_pll_phase_ctrl

Runtime controller for the Ethernet clocking PLL: it sequences PLL reset and lock qualification, then applies dynamic phase-shift commands to any of NUM_CH output counters. It is the parametrised successor to the fixed-phase RGMII PLL wrapper. Instead of relying on compile-time 0 ps / 2000 ps TX/RX skews, firmware trims per-port clock phase in VCO steps, and the block tracks each channel's accumulated offset. It sits between the CSR block (command side) and the PLL dynamic-phase pins (phase_en/updn/cntsel/phase_done).

## Interface
- NUM_CH, 6: number of phase-steppable output counters, 1..18; channel n drives cntsel = n.
- STEP_W, 8: width of cmd_steps.
- PHASE_W, 10: width of each per-channel phase accumulator, two's complement.
- RST_CYC, 8: pll_rst assertion length in cycles, ≥ 2.
- LOCK_FILT, 16: consecutive synchronized-lock cycles required before locked rises.
- DONE_TMO, 1024: cycles to wait for phase_done before aborting a step.

Ports:
- refclk  in  1  controller clock (PLL reference, 25 MHz).
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous; 2-flop synchronized.
- pll_rst  out  1  PLL reset.
- phase_en  out  1  phase-step request to PLL.
- updn  out  1  step direction: 1 = advance, 0 = retard.
- cntsel  out  5  counter select.
- phase_done  in  1  PLL step-complete, asynchronous; 2-flop synchronized, rising-edge detected.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ch  in  5  target channel.
- cmd_dir  in  1  direction, same encoding as updn.
- cmd_steps  in  STEP_W  number of VCO phase steps.
- locked  out  1  filtered lock.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on command completion.
- err_badch  out  1  one-cycle pulse: cmd_ch ≥ NUM_CH.
- err_tmo  out  1  one-cycle pulse: phase_done timeout.
- ch_phase  out  NUM_CH*PHASE_W  accumulators; channel n at [n*PHASE_W +: PHASE_W].

## Operation
- States: RESET_PLL, WAIT_LOCK, IDLE, STEP_EN, STEP_WAIT, STEP_GAP.
- RESET_PLL:
  - pll_rst = 1 for RST_CYC cycles.
  - All ch_phase are cleared.
  - Then go to WAIT_LOCK.
- WAIT_LOCK:
  - A filter counter increments while the synced lock is 1 and clears to 0 on any 0.
  - When the counter reaches LOCK_FILT, locked = 1 and the state goes to IDLE.
- IDLE: cmd_ready = 1. On accept:
  - cmd_ch ≥ NUM_CH: err_badch pulses next cycle; no step is issued; stay in IDLE.
  - cmd_steps = 0: done pulses next cycle; stay in IDLE.
  - Otherwise: latch ch/dir/steps, remaining = cmd_steps, go to STEP_EN.
- STEP_EN:
  - phase_en = 1 for exactly 2 cycles, with cntsel = ch and updn = dir.
  - cntsel and updn hold stable from STEP_EN through STEP_WAIT.
  - Then go to STEP_WAIT and clear the timeout counter.
- STEP_WAIT, on the synced phase_done rising edge:
  - ch_phase[ch] ±= 1, modulo 2^PHASE_W (wraps 511 → -512 and -512 → 511).
  - remaining -= 1.
  - If remaining = 0: done pulse, go to IDLE. Otherwise go to STEP_GAP (1 cycle), then STEP_EN.
- STEP_WAIT timeout: if the timeout counter reaches DONE_TMO, err_tmo pulses, there is no done pulse, the accumulator keeps the steps already completed, and the state goes to IDLE.
- Lock loss: a synced lock of 0 in IDLE, STEP_EN, STEP_WAIT or STEP_GAP:
  - locked drops the next cycle and any command in flight is aborted without done.
  - Next state is set by the macro (see Configuration).
- Simultaneous lock loss and phase_done edge: lock loss wins, and the accumulator is not updated.

## Timing
- Reset values: pll_rst = 1, phase_en = 0, updn = 0, cntsel = 0, cmd_ready = 0, locked = 0, busy = 1, done / err_* = 0, ch_phase all 0, state = RESET_PLL.
- Command accepted at cycle T: cmd_ready = 0 at T+1, phase_en = 1 at T+1 and T+2.
- Completion: done and cmd_ready = 1 in the cycle after the synced phase_done edge is detected.
- phase_done input to internal edge: 3 refclk cycles (2 sync + edge register).
- Per-step overhead excluding PLL response: 2 (phase_en) + 3 (sync) + 1 (gap) cycles.
- Lock: locked rises LOCK_FILT + 2 cycles after pll_locked goes stably high.
- All outputs are registered.

## Configuration
- Macro: ETH_PLL_AUTO_RELOCK_EN.
- Defined: lock loss goes to RESET_PLL, so the PLL is re-reset and all ch_phase clear to 0.
- Undefined: lock loss goes to WAIT_LOCK; there is no pll_rst pulse and ch_phase is retained.

## Test plan
- Reset release, pll_locked high from cycle 12 → pll_rst high for 8 cycles, locked rises at cycle 30, cmd_ready = 1.
- cmd ch = 1, dir = 1, steps = 3, with a PLL model answering phase_done 4 cycles after phase_en → 3 phase_en pairs, cntsel = 1, done once, ch_phase[1] = 3.
- cmd ch = 2, dir = 0, steps = 1, starting from 0 → ch_phase[2] = -1 (0x3FF); a preset of -512 retarded once wraps to 511.
- cmd ch = 7 with NUM_CH = 6 → err_badch pulse, no phase_en; cmd steps = 0 → done next cycle, no phase_en.
- phase_done held low → err_tmo exactly DONE_TMO cycles after entering STEP_WAIT, no done, back to IDLE.
- pll_locked dropped mid-command (steps = 5, after 2 steps):
  - Macro defined: pll_rst pulses and ch_phase clears.
  - Macro undefined: no pll_rst, ch_phase = 2, no done.
